// File: rtl/scheduler_pkg.sv
`default_nettype none
// ============================================================================
// scheduler_pkg : shared widths, router spike packet and scheduler states
// Rev 1.0
// ============================================================================
package scheduler_pkg;

    localparam int c_num_axons_def = 256;
    localparam int c_num_ticks_def = 16;

    function automatic int axon_w(input int num_axons);
        return (num_axons > 1) ? $clog2(num_axons) : 1;
    endfunction

    function automatic int delay_w(input int num_ticks);
        return (num_ticks > 1) ? $clog2(num_ticks) : 1;
    endfunction

    localparam int c_axon_w_def  = axon_w(c_num_axons_def);
    localparam int c_delay_w_def = delay_w(c_num_ticks_def);

    typedef struct packed {
        logic [c_axon_w_def-1:0]  axon;
        logic [c_delay_w_def-1:0] delay;
    } spike_pkt_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/scheduler_slot_mem.sv
`default_nettype none
// ============================================================================
// scheduler_slot_mem : NUM_TICKS x NUM_AXONS spike bit array
// Rev 1.0
// ============================================================================
module scheduler_slot_mem #(
    parameter int NUM_AXONS = 256,
    parameter int NUM_TICKS = 16,
    parameter int AXON_W    = 8,
    parameter int DELAY_W   = 4
) (
    input  logic                 clk,
    input  logic                 set_en,
    input  logic [DELAY_W-1:0]   set_row,
    input  logic [AXON_W-1:0]    set_col,
    input  logic                 clr_en,
    input  logic [DELAY_W-1:0]   clr_row,
    input  logic [DELAY_W-1:0]   rd_row,
    output logic [NUM_AXONS-1:0] rd_data
);

    logic [NUM_AXONS-1:0] mem_q [NUM_TICKS];
    logic [NUM_AXONS-1:0] mem_d [NUM_TICKS];

    // Set is applied after clear so a same-row set would survive; the caller
    // never targets the row it is clearing in the same cycle.
    always_comb begin
        mem_d = mem_q;
        if (clr_en) begin
            mem_d[clr_row] = '0;
        end
        if (set_en) begin
            mem_d[set_row][set_col] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_row];

endmodule
`default_nettype wire

// File: rtl/spike_scheduler.sv
`default_nettype none
// ============================================================================
// spike_scheduler : circular future-tick spike buffer feeding the token controller
// Rev 1.0
// ============================================================================
module spike_scheduler
    import scheduler_pkg::*;
#(
    parameter int  NUM_AXONS = 256,
    parameter int  NUM_TICKS = 16,
    localparam int AXON_W    = axon_w(NUM_AXONS),
    localparam int DELAY_W   = delay_w(NUM_TICKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    output logic                 pkt_ready,
    input  logic [AXON_W-1:0]    pkt_axon,
    input  logic [DELAY_W-1:0]   pkt_delay,
    input  logic                 scheduler_set,
    input  logic                 scheduler_clr,
    output logic [NUM_AXONS-1:0] axon_spikes,
    output logic                 busy,
    output logic [DELAY_W-1:0]   tick_ptr,
    output logic                 error
);

    localparam logic [DELAY_W-1:0] LAST_SLOT = DELAY_W'(NUM_TICKS - 1);

    sched_state_t       state_q, state_d;
    logic [DELAY_W-1:0] init_cnt_q, init_cnt_d;
    logic [DELAY_W-1:0] rd_ptr_q, rd_ptr_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic               mem_set_en;
    logic               mem_clr_en;
    logic [DELAY_W-1:0] mem_clr_row;
    logic [DELAY_W-1:0] pkt_target;
    logic               pkt_axon_oob;

    // Target is relative to the pre-update pointer, so it can never equal the slot cleared this cycle.
    assign pkt_target   = rd_ptr_q + 1'b1 + pkt_delay;
    assign pkt_axon_oob = (32'(pkt_axon) >= 32'(NUM_AXONS));

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        busy_d      = busy_q;
        error_d     = error_q;
        mem_set_en  = 1'b0;
        mem_clr_en  = 1'b0;
        mem_clr_row = rd_ptr_q;
        pkt_ready   = 1'b0;

        case (state_q)
            ST_INIT: begin
                mem_clr_en  = 1'b1;
                mem_clr_row = init_cnt_q;
                init_cnt_d  = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_SLOT) begin
                    state_d = ST_RUN;
                end
                if (scheduler_set || scheduler_clr) begin
                    error_d = 1'b1;
                end
            end
            ST_RUN: begin
                pkt_ready = 1'b1;
                if (pkt_valid) begin
                    if ((pkt_delay == LAST_SLOT) || pkt_axon_oob) begin
                        error_d = 1'b1;
                    end else begin
                        mem_set_en = 1'b1;
                    end
                end
                if (scheduler_set) begin
                    if (busy_q) begin
                        error_d = 1'b1;
                    end
                    busy_d = 1'b1;
                end
                if (scheduler_clr) begin
                    if (!busy_q || scheduler_set) begin
                        error_d = 1'b1;
                    end
                    mem_clr_en = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    scheduler_slot_mem #(
        .NUM_AXONS (NUM_AXONS),
        .NUM_TICKS (NUM_TICKS),
        .AXON_W    (AXON_W),
        .DELAY_W   (DELAY_W)
    ) u_slot_mem (
        .clk     (clk),
        .set_en  (mem_set_en),
        .set_row (pkt_target),
        .set_col (pkt_axon),
        .clr_en  (mem_clr_en),
        .clr_row (mem_clr_row),
        .rd_row  (rd_ptr_q),
        .rd_data (axon_spikes)
    );

    assign busy     = busy_q;
    assign tick_ptr = rd_ptr_q;
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_scheduler.sv
`default_nettype none
// ============================================================================
// tb_spike_scheduler : random + directed stimulus against a slot-array model
// Rev 1.0
// ============================================================================
module tb_spike_scheduler;

    localparam int NA = 256;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pkt_valid = 1'b0;
    logic          pkt_ready;
    logic [7:0]    pkt_axon = '0;
    logic [3:0]    pkt_delay = '0;
    logic          scheduler_set = 1'b0;
    logic          scheduler_clr = 1'b0;
    logic [NA-1:0] axon_spikes;
    logic          busy;
    logic [3:0]    tick_ptr;
    logic          error;

    always #5 clk = ~clk;

    spike_scheduler #(.NUM_AXONS(NA), .NUM_TICKS(NT)) dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_axon      (pkt_axon),
        .pkt_delay     (pkt_delay),
        .scheduler_set (scheduler_set),
        .scheduler_clr (scheduler_clr),
        .axon_spikes   (axon_spikes),
        .busy          (busy),
        .tick_ptr      (tick_ptr),
        .error         (error)
    );

    typedef struct {
        logic [NA-1:0] spikes;
        int            ptr;
        bit            busy;
        bit            err;
        bit            ready;
        bit            chk_sp;
        int            due;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: one bit vector per future tick, plain modular arithmetic
    bit [NA-1:0] m_slot [NT];
    int          m_ptr;
    bit          m_busy;
    bit          m_err;
    int          m_init;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [NA-1:0] act, logic [NA-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].due <= cyc) begin
                me = q.pop_front();
                chk("pkt_ready", NA'(pkt_ready), NA'(me.ready));
                chk("tick_ptr",  NA'(tick_ptr),  NA'(me.ptr));
                chk("busy",      NA'(busy),      NA'(me.busy));
                chk("error",     NA'(error),     NA'(me.err));
                if (me.chk_sp) chk("axon_spikes", axon_spikes, me.spikes);
            end
        end
    end

    task automatic step(input bit v, input int ax, input int dl,
                        input bit s, input bit c, input bit r);
        exp_t e;
        int   tgt;
        bit   old_busy;
        @(negedge clk);
        rst           = r;
        pkt_valid     = v;
        pkt_axon      = 8'(ax);
        pkt_delay     = 4'(dl);
        scheduler_set = s;
        scheduler_clr = c;
        if (!r) begin
            for (int i = 0; i < NT; i++) m_slot[i] = '0;
            m_ptr  = 0;
            m_busy = 0;
            m_err  = 0;
            m_init = NT;
        end else if (m_init > 0) begin
            if (s || c) m_err = 1;
            m_init--;
        end else begin
            tgt      = (m_ptr + 1 + dl) % NT;
            old_busy = m_busy;
            if (s && old_busy)  m_err = 1;
            if (c && !old_busy) m_err = 1;
            if (s && c)         m_err = 1;
            if (c) begin
                m_slot[m_ptr] = '0;
                m_ptr         = (m_ptr + 1) % NT;
            end
            m_busy = c ? 1'b0 : (s ? 1'b1 : old_busy);
            if (v) begin
                if (dl == NT - 1) m_err = 1;
                else              m_slot[tgt][ax] = 1'b1;
            end
        end
        e.spikes = m_slot[m_ptr];
        e.ptr    = m_ptr;
        e.busy   = m_busy;
        e.err    = m_err;
        e.ready  = r && (m_init == 0);
        e.chk_sp = r && (m_init == 0);
        e.due    = cyc + 1;
        q.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 1);
    endtask

    task automatic pair();
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1);
    endtask

    // Two reset cycles, then NT initialisation cycles with ignored traffic
    task automatic reset_seq(input bit poke);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NT; i++)
            step(i == 5, 9, 0, poke && (i == 3), 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit v, s, c, viol;
        int ax, dl;

        reset_seq(0);

        step(1, 5, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 1, 1);

        step(1, 3, 2, 0, 0, 1);
        step(1, 3, 2, 0, 0, 1);
        repeat (4) pair();
        repeat (16) pair();

        step(1, 10, 15, 0, 0, 1);
        repeat (16) pair();

        reset_seq(0);
        repeat (4) pair();
        step(0, 0, 0, 1, 0, 1);
        step(1, 7, 0, 0, 1, 1);
        idle();

        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        idle();

        reset_seq(0);
        step(0, 0, 0, 0, 1, 1);
        idle();

        reset_seq(0);
        step(0, 0, 0, 1, 1, 1);
        idle();

        reset_seq(1);
        idle();

        for (int round = 0; round < 3; round++) begin
            reset_seq(0);
            for (int k = 0; k < 600; k++) begin
                v    = ($urandom_range(0, 1) == 1);
                ax   = int'($urandom_range(0, NA - 1));
                dl   = ($urandom_range(0, 199) == 0) ? NT - 1 : int'($urandom_range(0, NT - 2));
                viol = ($urandom_range(0, 99) == 0);
                s    = !m_busy ? ($urandom_range(0, 3) == 0) : viol;
                c    = m_busy  ? ($urandom_range(0, 3) == 0) : viol;
                step(v, ax, dl, s, c, 1);
            end
        end

        idle();
        for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
